// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants for the nibble-serial adder
package adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/fulladder4b.sv
// rtl/fulladder4b.sv - 4-bit combinational adder with carry in/out
module fulladder4b (
  input  logic [3:0] X,
  input  logic [3:0] Y,
  input  logic       CARRY_IN,
  output logic [3:0] SUM,
  output logic       CARRY_OUT
);

  assign {CARRY_OUT, SUM} = {1'b0, X} + {1'b0, Y} + {4'b0000, CARRY_IN};

endmodule

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - wide adder built from one 4-bit adder, one nibble per clock
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    IN_VALID,
  output logic                    IN_READY,
  input  logic [4*NIBBLES-1:0]    A,
  input  logic [4*NIBBLES-1:0]    B,
  input  logic                    CIN,
  output logic                    OUT_VALID,
  input  logic                    OUT_READY,
  output logic [4*NIBBLES-1:0]    RESULT,
  output logic                    COUT,
  output logic                    OVF
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic               carry_q;
  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;
  logic [NIBBLE_W-1:0] nib_sum;
  logic               nib_cout;
  logic               ovf_next;

  fulladder4b u_nibble (
    .X         (a_q[{idx, 2'b00} +: NIBBLE_W]),
    .Y         (b_q[{idx, 2'b00} +: NIBBLE_W]),
    .CARRY_IN  (carry_q),
    .SUM       (nib_sum),
    .CARRY_OUT (nib_cout)
  );

  // Signed overflow: operands agree in sign but the top nibble's sign bit disagrees.
  assign ovf_next = (a_q[W-1] == b_q[W-1]) && (nib_sum[NIBBLE_W-1] != a_q[W-1]);
  assign IN_READY = (state == ST_IDLE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      idx       <= '0;
      carry_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      RESULT    <= '0;
      COUT      <= 1'b0;
      OVF       <= 1'b0;
      OUT_VALID <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          OUT_VALID <= 1'b0;
          if (IN_VALID) begin
            a_q     <= A;
            b_q     <= B;
            carry_q <= CIN;
            idx     <= '0;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          RESULT[{idx, 2'b00} +: NIBBLE_W] <= nib_sum;
          carry_q <= nib_cout;
          if (idx == IDX_LAST) begin
            COUT      <= nib_cout;
            OVF       <= ovf_next;
            OUT_VALID <= 1'b1;
            state     <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (OUT_READY) begin
            OUT_VALID <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          OUT_VALID <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - directed self-checking bench for nibble_serial_adder
module tb_nibble_serial_adder;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        CIN = 1'b0;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b0;
  logic [15:0] RESULT;
  logic        COUT;
  logic        OVF;

  int n_checks = 0;
  int n_fail   = 0;

  nibble_serial_adder #(.NIBBLES(4)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .A         (A),
    .B         (B),
    .CIN       (CIN),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .RESULT    (RESULT),
    .COUT      (COUT),
    .OVF       (OVF)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Accept one operand pair and wait the four nibble edges; optionally acknowledge the result.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic [15:0] er, input logic ec,
                        input logic eo, input bit ack);
    check({tag, "_in_ready_idle"}, 32'(IN_READY), 32'd1);
    A = a; B = b; CIN = cin; IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    A = ~a; B = ~b; CIN = ~cin;
    for (int i = 0; i < 4; i++) begin
      check({tag, "_busy_in_ready"}, 32'(IN_READY), 32'd0);
      check({tag, "_busy_out_valid"}, 32'(OUT_VALID), 32'd0);
      tick();
    end
    check({tag, "_out_valid"}, 32'(OUT_VALID), 32'd1);
    check({tag, "_result"}, 32'(RESULT), 32'(er));
    check({tag, "_cout"}, 32'(COUT), 32'(ec));
    check({tag, "_ovf"}, 32'(OVF), 32'(eo));
    if (ack) begin
      OUT_READY = 1'b1;
      tick();
      OUT_READY = 1'b0;
      check({tag, "_ack_in_ready"}, 32'(IN_READY), 32'd1);
      check({tag, "_ack_out_valid"}, 32'(OUT_VALID), 32'd0);
    end
  endtask

  initial begin
    #1;
    check("reset_in_ready", 32'(IN_READY), 32'd1);
    check("reset_out_valid", 32'(OUT_VALID), 32'd0);
    tick();
    RST = 1'b0;
    tick();
    check("reset_result", 32'(RESULT), 32'd0);
    check("reset_cout", 32'(COUT), 32'd0);
    check("reset_ovf", 32'(OVF), 32'd0);

    run_op("simple", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b1);

    // Reset while idle clears the held result
    RST = 1'b1;
    #1;
    check("idle_rst_result", 32'(RESULT), 32'd0);
    check("idle_rst_out_valid", 32'(OUT_VALID), 32'd0);
    check("idle_rst_in_ready", 32'(IN_READY), 32'd1);
    tick();
    RST = 1'b0;
    tick();

    run_op("ripple", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
    run_op("ovf_neg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);

    // Backpressure: hold result while inputs churn
    run_op("bp", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
    IN_VALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      A = 16'(i * 16'h1111); B = ~A; CIN = i[0];
      tick();
      check("bp_out_valid", 32'(OUT_VALID), 32'd1);
      check("bp_result", 32'(RESULT), 32'h5555);
      check("bp_cout", 32'(COUT), 32'd0);
      check("bp_in_ready", 32'(IN_READY), 32'd0);
    end
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    check("bp_release_in_ready", 32'(IN_READY), 32'd1);
    check("bp_release_out_valid", 32'(OUT_VALID), 32'd0);
    run_op("bp_next", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b1);

    // Reset after two nibble edges aborts the transaction
    A = 16'hFFFF; B = 16'h0001; CIN = 1'b0; IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    tick();
    tick();
    RST = 1'b1;
    #1;
    check("run_rst_out_valid", 32'(OUT_VALID), 32'd0);
    check("run_rst_result", 32'(RESULT), 32'd0);
    check("run_rst_cout", 32'(COUT), 32'd0);
    check("run_rst_ovf", 32'(OVF), 32'd0);
    check("run_rst_in_ready", 32'(IN_READY), 32'd1);
    tick();
    RST = 1'b0;
    tick();
    run_op("post_rst", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
